// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory-BIST sequencer.
// Each table entry says how one march element walks the array and what it reads/writes.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned NUM_ELEMS = 6;
    localparam logic [2:0] ELEM_M0 = 3'd0;
    localparam logic [2:0] ELEM_M1 = 3'd1;
    localparam logic [2:0] ELEM_M2 = 3'd2;
    localparam logic [2:0] ELEM_M3 = 3'd3;
    localparam logic [2:0] ELEM_M4 = 3'd4;
    localparam logic [2:0] ELEM_M5 = 3'd5;

    // Cycles spent after the last op so the final read can be compared.
    localparam int unsigned FLUSH_LEN   = 1;
    localparam int unsigned FLUSH_CNT_W = 2;

    typedef struct packed {
        logic down;      // walk addresses from the top down
        logic two_op;    // read followed by write at each address
        logic first_rd;  // first op at each address is a read
        logic rd_val;    // expected value of the read (0 = BG, 1 = ~BG)
        logic wr_val;    // value written (0 = BG, 1 = ~BG)
    } elem_cfg_t;

    // Index i holds element Mi.
    localparam elem_cfg_t [NUM_ELEMS-1:0] ELEM_TABLE = {
        elem_cfg_t'{down: 1'b1, two_op: 1'b0, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b0},  // M5 down(r0)
        elem_cfg_t'{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0},  // M4 down(r1,w0)
        elem_cfg_t'{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1},  // M3 down(r0,w1)
        elem_cfg_t'{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0},  // M2 up(r1,w0)
        elem_cfg_t'{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1},  // M1 up(r0,w1)
        elem_cfg_t'{down: 1'b0, two_op: 1'b0, first_rd: 1'b0, rd_val: 1'b0, wr_val: 1'b0}   // M0 up(w0)
    };

    function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
        elem_cfg_t c;
        c = '0;
        if (e < 3'(NUM_ELEMS)) begin
            c = ELEM_TABLE[e];
        end
        return c;
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-compare pipeline: registers the issued read, checks rdata one cycle later,
// and holds a sticky fail flag with the address/element of the first mismatch.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_elem,
    input  logic [DATA_W-1:0] rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        elem_q, elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic              mismatch;

    always_comb begin
        vld_d       = rd_vld;
        exp_d       = rd_exp;
        addr_d      = rd_addr;
        elem_d      = rd_elem;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        mismatch    = vld_q && (rdata != exp_q);

        if (clear) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (mismatch && !fail_q) begin
            // Only the first failure of a run is recorded.
            fail_d      = 1'b1;
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= 1'b0;
            exp_q       <= '0;
            addr_q      <= '0;
            elem_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: rtl/mbist_march_gen.sv
// March C- memory-BIST sequencer: walks elements M0..M5 over the SRAM, driving
// addr/wdata/we/re directly, and hands each read to mbist_cmp for checking.
module mbist_march_gen
    import mbist_pkg::*;
#(
    parameter int              ADDR_W = 8,
    parameter int              DATA_W = 4,
    parameter logic [DATA_W-1:0] BG   = {DATA_W/2{2'b01}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              re,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [ADDR_W-1:0]      ADDR_MAX   = '1;
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);

    state_t                 state_q, state_d;
    logic [2:0]             elem_q, elem_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   op_q, op_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    elem_cfg_t         cfg;
    elem_cfg_t         next_cfg;
    logic              run;
    logic              is_rd;
    logic              last_op;
    logic              last_addr;
    logic              op_val;
    logic              start_ok;
    logic [DATA_W-1:0] op_data;

    // Decode of the current op from the element table.
    always_comb begin
        cfg       = elem_cfg(elem_q);
        next_cfg  = elem_cfg(elem_q + 3'd1);
        run       = (state_q == ST_RUN);
        is_rd     = cfg.first_rd && !op_q;
        last_op   = !cfg.two_op || op_q;
        last_addr = cfg.down ? (addr_q == '0) : (addr_q == ADDR_MAX);
        op_val    = is_rd ? cfg.rd_val : cfg.wr_val;
        op_data   = op_val ? ~BG : BG;
        start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        op_d        = op_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    elem_d  = ELEM_M0;
                    addr_d  = '0;
                    op_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (last_addr) begin
                            if (elem_q == ELEM_M5) begin
                                state_d     = ST_FLUSH;
                                flush_cnt_d = '0;
                            end else begin
                                // Jump straight to the next element's first address.
                                elem_d = elem_q + 3'd1;
                                addr_d = next_cfg.down ? ADDR_MAX : '0;
                            end
                        end else begin
                            addr_d = cfg.down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign addr  = run ? addr_q : '0;
    assign wdata = (run && !is_rd) ? op_data : '0;
    assign we    = run && en && !is_rd;
    assign re    = run && en && is_rd;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done  = (state_q == ST_DONE);

    mbist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .rd_vld    (re),
        .rd_exp    (op_data),
        .rd_addr   (addr_q),
        .rd_elem   (elem_q),
        .rdata     (rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_mbist_march_gen.sv
// Bench for mbist_march_gen: behavioural SRAM with injectable faults, an op-list
// model of March C-, and a per-cycle monitor comparing the DUT op stream to it.
module tb_mbist_march_gen;

    localparam int AW    = 2;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int N     = 10 * DEPTH;
    localparam logic [DW-1:0] BG = 4'b0101;
    localparam int MW    = 2 + AW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          en;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int n_vec  = 0;
    int n_miss = 0;

    mbist_march_gen #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .BG     (BG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (en),
        .rdata     (rdata),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    // Expected op list: m_rd=1 read expecting m_data, else write m_data.
    bit            m_rd   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    logic [2:0]    m_elem [N];

    // Fault injection: stuck bits at one address, and/or inversion of the n-th read.
    int            stuck_addr = -1;
    logic [DW-1:0] stuck_mask = '0;
    logic [DW-1:0] stuck_val  = '0;
    int            flip_read  = -1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input int a, input int rn);
        logic [DW-1:0] r;
        r = d;
        if (a == stuck_addr) r = (r & ~stuck_mask) | (stuck_val & stuck_mask);
        if (rn == flip_read) r = ~r;
        return r;
    endfunction

    task automatic build_ops();
        int n;
        int a;
        n = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (e >= 3) ? DEPTH - 1 - k : k;
                // Read value then write value of each element, 0 = BG, 1 = ~BG.
                if (e >= 1) begin
                    m_rd[n] = 1'b1; m_addr[n] = AW'(a); m_elem[n] = 3'(e);
                    m_data[n] = (e == 2 || e == 4) ? ~BG : BG;
                    n++;
                end
                if (e <= 4) begin
                    m_rd[n] = 1'b0; m_addr[n] = AW'(a); m_elem[n] = 3'(e);
                    m_data[n] = (e == 1 || e == 3) ? ~BG : BG;
                    n++;
                end
            end
        end
    endtask

    // Replays the op list against a model memory carrying the same faults.
    task automatic model_result(output bit f, output int fa, output int fe, output int fidx);
        logic [DW-1:0] mm [DEPTH];
        logic [DW-1:0] got;
        int rn;
        rn = 0; f = 0; fa = 0; fe = 0; fidx = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_rd[i]) begin
                mm[int'(m_addr[i])] = m_data[i];
            end else begin
                got = faulty(mm[int'(m_addr[i])], int'(m_addr[i]), rn);
                rn++;
                if (got != m_data[i] && !f) begin
                    f = 1; fa = int'(m_addr[i]); fe = int'(m_elem[i]); fidx = i;
                end
            end
        end
    endtask

    // Behavioural SRAM with one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    int rd_count = 0;
    always @(posedge clk) begin
        if (start && !busy) rd_count <= 0;
        if (we) mem[addr] <= wdata;
        if (re) begin
            rdata    <= faulty(mem[addr], int'(addr), rd_count);
            rd_count <= rd_count + 1;
        end
    end

    // Per-cycle op-stream monitor.
    bit mon_on = 0;
    int op_idx = 0;
    logic [MW-1:0] m_act;
    logic [MW-1:0] m_exp;
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy && op_idx < N && en) begin
                m_act = {we, re, addr, (we ? wdata : {DW{1'b0}})};
                m_exp = {!m_rd[op_idx], m_rd[op_idx], m_addr[op_idx],
                         (m_rd[op_idx] ? {DW{1'b0}} : m_data[op_idx])};
                check($sformatf("op[%0d]", op_idx), 64'(m_act), 64'(m_exp));
                op_idx++;
            end else begin
                check($sformatf("idle_strobes[%0d]", op_idx), 64'({we, re}), 64'(2'b00));
            end
            if (!busy) op_idx = 0;
        end
    end

    task automatic set_fault(input int sa, input logic [DW-1:0] sm, input logic [DW-1:0] sv, input int fr);
        stuck_addr = sa; stuck_mask = sm; stuck_val = sv; flip_read = fr;
    endtask

    task automatic do_run(input string nm, input int en_mode, input int mid_start_at,
                          input int rst_at, input int exp_done_edge);
        bit f;
        int fa, fe, fidx;
        int issued, stalls, cyc;
        bit e;
        bit exp_early;
        logic [AW-1:0] efa;
        logic [2:0]    efe;
        model_result(f, fa, fe, fidx);
        exp_early = f && (fidx != N - 1);
        efa = f ? AW'(fa) : '0;
        efe = f ? 3'(fe) : 3'd0;

        start = 1'b1;
        en    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_start"}, 64'({busy, done, fail, fail_addr, fail_elem}),
              64'({1'b1, 1'b0, 1'b0, {AW{1'b0}}, 3'd0}));

        issued = 0; stalls = 0; cyc = 0;
        while (issued < N) begin
            case (en_mode)
                0:       e = 1'b1;
                1:       e = ((cyc % 2) != 0);
                default: e = ($urandom_range(0, 3) != 0);
            endcase
            if (rst_at >= 0 && issued == rst_at) e = 1'b1;
            en    = e;
            start = (cyc == mid_start_at);
            rst   = (rst_at >= 0 && issued == rst_at);
            if (e) issued++; else stalls++;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (rst) begin
                rst = 1'b0;
                check({nm, "_midrst"}, 64'({busy, done, fail, we, re}), 64'(5'b0));
                return;
            end
        end

        en = 1'($urandom_range(0, 1));
        check({nm, "_flush"}, 64'({busy, done, fail}), 64'({1'b1, 1'b0, exp_early}));
        @(posedge clk); #1;
        check({nm, "_done"}, 64'({busy, done, fail, fail_addr, fail_elem}),
              64'({1'b0, 1'b1, f, efa, efe}));
        if (exp_done_edge > 0) check({nm, "_done_edge"}, 64'(N + stalls + 2), 64'(exp_done_edge));
        $display("run %s: ops=%0d stalls=%0d fail=%0b fail_addr=%0d fail_elem=%0d",
                 nm, N, stalls, fail, fail_addr, fail_elem);
    endtask

    initial begin
        bit f;
        int fa, fe, fi;
        int nreads;
        rst = 1'b1; start = 1'b0; en = 1'b0;
        build_ops();
        nreads = 0;
        for (int i = 0; i < N; i++) if (m_rd[i]) nreads++;

        repeat (3) @(posedge clk);
        #1;
        check("reset", 64'({addr, wdata, we, re, busy, done, fail, fail_addr, fail_elem}), 64'(0));
        rst = 1'b0;
        mon_on = 1;

        // Hand-computed expectations pinning the model itself.
        check("model_m0_writes", 64'({m_rd[0], m_addr[0], m_data[0], m_rd[1], m_addr[1], m_data[1],
                                     m_rd[2], m_addr[2], m_data[2], m_rd[3], m_addr[3], m_data[3]}),
              64'({1'b0, 2'd0, 4'b0101, 1'b0, 2'd1, 4'b0101, 1'b0, 2'd2, 4'b0101, 1'b0, 2'd3, 4'b0101}));
        check("model_m3_reads", 64'({m_addr[20], m_addr[22], m_addr[24], m_addr[26], m_elem[24], m_data[24]}),
              64'({2'd3, 2'd2, 2'd1, 2'd0, 3'd3, 4'b0101}));
        set_fault(2, 4'b0010, 4'b0010, -1);
        model_result(f, fa, fe, fi);
        check("model_stuck_b1", 64'({f, 2'(fa), 3'(fe)}), 64'({1'b1, 2'd2, 3'd1}));
        set_fault(2, 4'b0001, 4'b0001, -1);
        model_result(f, fa, fe, fi);
        check("model_stuck_b0", 64'({f, 2'(fa), 3'(fe)}), 64'({1'b1, 2'd2, 3'd2}));
        set_fault(-1, '0, '0, nreads - 1);
        model_result(f, fa, fe, fi);
        check("model_last_read", 64'({f, 2'(fa), 3'(fe)}), 64'({1'b1, 2'd0, 3'd5}));

        set_fault(-1, '0, '0, -1);
        do_run("clean", 0, -1, -1, 42);
        set_fault(2, 4'b0010, 4'b0010, -1);
        do_run("stuck_b1", 0, -1, -1, 42);
        set_fault(-1, '0, '0, -1);
        do_run("toggle_en", 1, 10, -1, 82);
        set_fault(2, 4'b0001, 4'b0001, -1);
        do_run("stuck_b0", 2, 5, -1, -1);
        set_fault(-1, '0, '0, nreads - 1);
        do_run("last_read", 0, -1, -1, 42);
        set_fault(2, 4'b0010, 4'b0010, -1);
        do_run("rst_m3a1", 0, -1, 24, -1);
        set_fault(-1, '0, '0, -1);
        do_run("after_rst", 0, -1, -1, 42);

        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                0: set_fault(-1, '0, '0, -1);
                1: set_fault(int'($urandom_range(0, DEPTH - 1)), DW'(1 << $urandom_range(0, DW - 1)),
                             DW'($urandom), -1);
                default: set_fault(-1, '0, '0, int'($urandom_range(0, nreads - 1)));
            endcase
            do_run($sformatf("rand%0d", r), 2, int'($urandom_range(0, 60)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
